// File: rtl/hack_pkg.sv
// Shared types for the Hack memory hierarchy: word/address types,
// RAM8 controller state encoding and bank depth.
package hack_pkg;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  addr8_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ram_state_e;

    localparam int RAM8_DEPTH = 8;

endpackage

// File: rtl/mux8way16.sv
// 8-way 16-bit combinational selector used as the RAM8 read path.
module mux8way16
    import hack_pkg::*;
(
    input  word_t [RAM8_DEPTH-1:0] data_i,
    input  addr8_t                 sel_i,
    output word_t                  out_o
);

    // Two-level tree mirroring the Hack Mux4Way16/Mux16 structure.
    word_t lo_sel;
    word_t hi_sel;

    always_comb begin
        lo_sel = data_i[{1'b0, sel_i[1:0]}];
        hi_sel = data_i[{1'b1, sel_i[1:0]}];
        out_o  = sel_i[2] ? hi_sel : lo_sel;
    end

endmodule

// File: rtl/register16.sv
// 16-bit Hack register: captures d_i on a rising edge when load_i is high,
// asynchronously cleared to zero by rst_n.
module register16
    import hack_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load_i,
    input  word_t d_i,
    output word_t q_o
);

    word_t data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ram8_ctrl.sv
// 8 x 16 Hack memory bank with a combinational read port and a clear-sweep
// FSM that zeroes the bank one word per cycle through the single write port.
module ram8_ctrl
    import hack_pkg::*;
#(
    parameter word_t CLEAR_VAL = 16'h0000
) (
    input  logic   clk,
    input  logic   rst_n,
    input  word_t  in,
    input  addr8_t address,
    input  logic   load,
    input  logic   clear,
    output word_t  out,
    output logic   ready,
    output logic   busy,
    output logic   done
);

    ram_state_e state_q;
    addr8_t     ptr_q;
    logic       done_q;

    logic                   wr_en;
    addr8_t                 wr_addr;
    word_t                  wr_data;
    logic  [RAM8_DEPTH-1:0] word_load;
    word_t [RAM8_DEPTH-1:0] word_q;

    // During a sweep the FSM owns the write port; CPU loads are dropped.
    always_comb begin
        wr_en   = load;
        wr_addr = address;
        wr_data = in;
        if (state_q == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = ptr_q;
            wr_data = CLEAR_VAL;
        end
    end

    generate
        for (genvar gi = 0; gi < RAM8_DEPTH; gi++) begin : g_word
            assign word_load[gi] = wr_en && (wr_addr == addr8_t'(gi));

            register16 u_word (
                .clk    (clk),
                .rst_n  (rst_n),
                .load_i (word_load[gi]),
                .d_i    (wr_data),
                .q_o    (word_q[gi])
            );
        end
    endgenerate

    mux8way16 u_read_mux (
        .data_i (word_q),
        .sel_i  (address),
        .out_o  (out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (clear) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                    end
                end
                CLEAR: begin
                    ptr_q <= ptr_q + 3'd1;
                    if (ptr_q == addr8_t'(RAM8_DEPTH - 1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == CLEAR);
    assign done  = done_q;

endmodule

// File: tb/tb_ram8_ctrl.sv
// Self-checking bench for ram8_ctrl: directed scenarios plus random traffic,
// compared each cycle against a word-array model with a sweep countdown.
module tb_ram8_ctrl;
    import hack_pkg::*;

    localparam word_t CV = 16'h0000;

    logic   clk     = 1'b0;
    logic   rst_n   = 1'b0;
    logic   load    = 1'b0;
    logic   clear   = 1'b0;
    word_t  in_w    = '0;
    addr8_t address = '0;
    word_t  out;
    logic   ready;
    logic   busy;
    logic   done;

    ram8_ctrl #(.CLEAR_VAL(CV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in_w),
        .address (address),
        .load    (load),
        .clear   (clear),
        .out     (out),
        .ready   (ready),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents, remaining sweep writes, next sweep slot.
    word_t mem_m [8];
    int    sweep_left = 0;
    int    sweep_idx  = 0;
    logic  done_m     = 1'b0;
    int    busy_cnt   = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && load === 1'b1) begin
            checks++;
            assert (!$isunknown(address)) else begin
                errors++;
                $error("FAIL addr_x observed=%b expected=known", address);
            end
        end
    end

    // One clock cycle: drive at negedge, compare outputs, then advance the model.
    task automatic step(input logic l, input logic c, input addr8_t a, input word_t d,
                        input string tag);
        @(negedge clk);
        load = l; clear = c; address = a; in_w = d;
        #1;
        check({tag, ".out"},   out,          mem_m[a]);
        check({tag, ".ready"}, 16'(ready),   16'(sweep_left == 0));
        check({tag, ".busy"},  16'(busy),    16'(sweep_left > 0));
        check({tag, ".done"},  16'(done),    16'(done_m));
        if (busy) busy_cnt++;
        $display("step %-10s l=%0d c=%0d a=%0d in=%h out=%h rdy=%0d bsy=%0d dn=%0d",
                 tag, l, c, a, d, out, ready, busy, done);
        @(posedge clk);
        if (sweep_left == 0) begin
            done_m = 1'b0;
            if (l) mem_m[a] = d;
            if (c) begin
                sweep_left = 8;
                sweep_idx  = 0;
            end
        end else begin
            mem_m[sweep_idx] = CV;
            sweep_idx++;
            sweep_left--;
            done_m = (sweep_left == 0);
        end
    endtask

    task automatic reset_checks(input string tag);
        for (int i = 0; i < 8; i++) begin
            address = addr8_t'(i);
            #1;
            check({tag, ".out"}, out, 16'h0000);
        end
        check({tag, ".ready"}, 16'(ready), 16'd1);
        check({tag, ".busy"},  16'(busy),  16'd0);
        check({tag, ".done"},  16'(done),  16'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem_m[i] = '0;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        reset_checks("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset then write/read
        step(1'b1, 1'b0, 3'd3, 16'hBEEF, "wr3");
        step(1'b0, 1'b0, 3'd3, 16'h0000, "rd3");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, addr8_t'(i), 16'h0, "rd_all");

        // Fill pattern; each write cycle also checks the old value is visible
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, addr8_t'(i), word_t'(16'h1111 * i), "fill");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, addr8_t'(i), 16'h0, "rd_fill");

        // Clear sweep over an all-ones bank
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, addr8_t'(i), 16'hFFFF, "fill_ff");
        busy_cnt = 0;
        step(1'b0, 1'b1, 3'd0, 16'h0, "clr");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, addr8_t'(i % 8), 16'h0, "sweep");
        check("busy_len", 16'(busy_cnt), 16'd8);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, addr8_t'(i), 16'h0, "rd_clr");

        // Load blocked during CLEAR
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, addr8_t'(i), 16'h5A5A, "fill_5a");
        step(1'b0, 1'b1, 3'd0, 16'h0, "clr2");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd7, 16'h0, "sweep2");
        step(1'b1, 1'b0, 3'd7, 16'h1234, "ld_blk");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 3'd7, 16'h0, "sweep2");
        step(1'b0, 1'b0, 3'd7, 16'h0, "rd7_clr");
        step(1'b1, 1'b0, 3'd7, 16'h1234, "ld_ok");
        step(1'b0, 1'b0, 3'd7, 16'h0, "rd7_new");

        // Simultaneous load+clear in IDLE
        step(1'b1, 1'b1, 3'd2, 16'hAAAA, "ld_clr");
        step(1'b0, 1'b0, 3'd2, 16'h0, "rd2_sw");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'd2, 16'h0, "sweep3");
        step(1'b0, 1'b0, 3'd2, 16'h0, "rd2_done");

        // Clear held high: back-to-back sweeps
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, addr8_t'($urandom_range(0, 7)), 16'h0, "clr_hold");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, addr8_t'(i % 8), 16'h0, "drain");

        // Reset mid-sweep
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, addr8_t'(i), word_t'($urandom), "fill_rnd");
        step(1'b0, 1'b1, 3'd6, 16'h0, "clr4");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'd6, 16'h0, "sweep4");
        @(negedge clk);
        load = 1'b0; clear = 1'b0; rst_n = 1'b0;
        for (int i = 0; i < 8; i++) mem_m[i] = '0;
        sweep_left = 0;
        done_m     = 1'b0;
        reset_checks("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, addr8_t'(i % 8), 16'h0, "post_rst");

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
                 addr8_t'($urandom_range(0, 7)), word_t'($urandom), "rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
